// File: rtl/bus_bridge_pkg.sv
// Shared types and constants for the bus bridge serial link.
package bus_bridge_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  write_data;
    logic        is_write;
  } bus_bridge_req_t;

  typedef struct packed {
    logic [7:0] read_data;
    logic       is_write;
  } bus_bridge_resp_t;

  localparam int unsigned BRIDGE_REQ_FRAME_BYTES  = 4;
  localparam int unsigned BRIDGE_RESP_FRAME_BYTES = 2;
  localparam int unsigned BRIDGE_FLAG_WRITE_BIT   = 0;

  typedef enum logic [3:0] {
    RX_ADDR_L,
    RX_ADDR_H,
    RX_DATA,
    RX_FLAGS,
    ISSUE,
    WAIT_RESP,
    TX_RD,
    TX_RD_WAIT,
    TX_FLAGS,
    TX_FLAGS_WAIT
  } bridge_init_uart_state_t;

endpackage

// File: rtl/uart.sv
// 8N1 UART: transmitter with busy flag, receiver with sticky ready flag.
module uart #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr_en,
  output logic                 Tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic [DATA_BITS-1:0] dout
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 3);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  TX_BITS   = BIT_W'(DATA_BITS + 2);
  localparam logic [BIT_W-1:0]  RX_STOP   = BIT_W'(DATA_BITS + 1);

  logic [DATA_BITS+1:0] tx_shift;
  logic [BIT_W-1:0]     tx_left;
  logic [TICK_W-1:0]    tx_tick;

  logic                 rx_meta, rx_s, rx_active;
  logic [TICK_W-1:0]    rx_tick;
  logic [BIT_W-1:0]     rx_idx;
  logic [DATA_BITS-1:0] rx_shift;

  assign tx      = tx_shift[0];
  assign Tx_busy = (tx_left != '0);

  // Transmit: shift out start, data LSB first, stop; line rests at all-ones.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_left  <= '0;
      tx_tick  <= '0;
    end else if (clear) begin
      tx_shift <= '1;
      tx_left  <= '0;
      tx_tick  <= '0;
    end else if (tx_left == '0) begin
      if (wr_en) begin
        tx_shift <= {1'b1, din, 1'b0};
        tx_left  <= TX_BITS;
        tx_tick  <= '0;
      end
    end else if (tx_tick == TICK_LAST) begin
      tx_tick  <= '0;
      tx_shift <= {1'b1, tx_shift[DATA_BITS+1:1]};
      tx_left  <= tx_left - 1'b1;
    end else begin
      tx_tick <= tx_tick + 1'b1;
    end
  end

  // Receive: synchronise, sample mid-bit, raise ready on a valid stop bit.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_active <= 1'b0;
      rx_tick   <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      dout      <= '0;
      ready     <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (ready_clr || clear) ready <= 1'b0;
      if (clear) begin
        rx_active <= 1'b0;
      end else if (!rx_active) begin
        if (!rx_s) begin
          rx_active <= 1'b1;
          rx_tick   <= '0;
          rx_idx    <= '0;
        end
      end else if (rx_tick == ((rx_idx == '0) ? TICK_HALF : TICK_LAST)) begin
        rx_tick <= '0;
        if (rx_idx == '0) begin
          if (rx_s) rx_active <= 1'b0;
          else      rx_idx    <= rx_idx + 1'b1;
        end else if (rx_idx == RX_STOP) begin
          rx_active <= 1'b0;
          if (rx_s) begin
            dout  <= rx_shift;
            ready <= 1'b1;
          end
        end else begin
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          rx_idx   <= rx_idx + 1'b1;
        end
      end else begin
        rx_tick <= rx_tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_bridge_initiator_uart_wrapper.sv
// Bus-B end of the bridge link: UART request frames in, bus transaction out,
// response frame back over UART. One transaction outstanding at a time.
module bus_bridge_initiator_uart_wrapper
  import bus_bridge_pkg::*;
#(
  parameter logic [31:0] BYTE_TIMEOUT = 32'd100000,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic             req_valid,
  input  logic             req_ready,
  output bus_bridge_req_t  req_payload,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  bus_bridge_resp_t resp_payload,
  output logic             busy,
  output logic [CNT_W-1:0] frame_err_count,
  output logic [CNT_W-1:0] overrun_count
);

  bridge_init_uart_state_t state, state_next;

  logic [7:0]       rx_data, tx_din;
  logic             rx_ready, rx_ready_q, ready_clr, rx_byte_evt;
  logic             tx_busy, tx_busy_q, tx_done, wr_en;
  logic [7:0]       addr_l, addr_h, wdata;
  logic             is_write_q, req_valid_q;
  bus_bridge_resp_t resp_q;
  logic [31:0]      to_cnt;
  logic             collecting, timeout_hit, frame_err_inc, overrun_inc;

  uart #(.DATA_BITS(8)) u_uart (
    .clk_50m   (clk),
    .rst_n     (rst_n),
    .clear     (1'b0),
    .din       (tx_din),
    .wr_en     (wr_en),
    .Tx_busy   (tx_busy),
    .tx        (uart_tx),
    .rx        (uart_rx),
    .ready     (rx_ready),
    .ready_clr (ready_clr),
    .dout      (rx_data)
  );

  assign rx_byte_evt = rx_ready & ~rx_ready_q;
  assign ready_clr   = rx_byte_evt;
  assign tx_done     = tx_busy_q & ~tx_busy;
  assign collecting  = (state == RX_ADDR_H) || (state == RX_DATA) || (state == RX_FLAGS);
  assign timeout_hit = (BYTE_TIMEOUT != '0) && collecting && (to_cnt >= BYTE_TIMEOUT);
  assign overrun_inc = rx_byte_evt && (state inside {ISSUE, WAIT_RESP, TX_RD, TX_RD_WAIT,
                                                     TX_FLAGS, TX_FLAGS_WAIT});

  assign req_valid   = req_valid_q;
  assign req_payload = {addr_h, addr_l, wdata, is_write_q};
  assign resp_ready  = (state == WAIT_RESP);
  assign busy        = (state != RX_ADDR_L);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_ADDR_L;
    else        state <= state_next;
  end

  // Next state, transmit strobes and error-count triggers.
  always_comb begin
    state_next    = state;
    wr_en         = 1'b0;
    tx_din        = resp_q.read_data;
    frame_err_inc = 1'b0;
    case (state)
      RX_ADDR_L: if (rx_byte_evt) state_next = RX_ADDR_H;
      RX_ADDR_H, RX_DATA: begin
        // A byte arriving in the timeout cycle still counts.
        if (rx_byte_evt) begin
          state_next = (state == RX_ADDR_H) ? RX_DATA : RX_FLAGS;
        end else if (timeout_hit) begin
          state_next    = RX_ADDR_L;
          frame_err_inc = 1'b1;
        end
      end
      RX_FLAGS: begin
        if (rx_byte_evt) begin
          if (rx_data[7:1] == '0) begin
            state_next = ISSUE;
          end else begin
            state_next    = RX_ADDR_L;
            frame_err_inc = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next    = RX_ADDR_L;
          frame_err_inc = 1'b1;
        end
      end
      ISSUE:      if (req_valid_q && req_ready) state_next = WAIT_RESP;
      WAIT_RESP:  if (resp_valid) state_next = TX_RD;
      TX_RD: begin
        if (!tx_busy) begin
          wr_en      = 1'b1;
          tx_din     = resp_q.read_data;
          state_next = TX_RD_WAIT;
        end
      end
      TX_RD_WAIT: if (tx_done) state_next = TX_FLAGS;
      TX_FLAGS: begin
        if (!tx_busy) begin
          wr_en      = 1'b1;
          tx_din     = {7'b0, resp_q.is_write};
          state_next = TX_FLAGS_WAIT;
        end
      end
      TX_FLAGS_WAIT: if (tx_done) state_next = RX_ADDR_L;
      default: state_next = RX_ADDR_L;
    endcase
  end

  // Edge-detect copies, frame capture, request/response registers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q      <= 1'b0;
      tx_busy_q       <= 1'b0;
      addr_l          <= '0;
      addr_h          <= '0;
      wdata           <= '0;
      is_write_q      <= 1'b0;
      req_valid_q     <= 1'b0;
      resp_q          <= '0;
      to_cnt          <= '0;
      frame_err_count <= '0;
      overrun_count   <= '0;
    end else begin
      rx_ready_q <= rx_ready;
      tx_busy_q  <= tx_busy;
      if (rx_byte_evt) begin
        case (state)
          RX_ADDR_L: addr_l <= rx_data;
          RX_ADDR_H: addr_h <= rx_data;
          RX_DATA:   wdata  <= rx_data;
          RX_FLAGS:  if (rx_data[7:1] == '0) is_write_q <= rx_data[BRIDGE_FLAG_WRITE_BIT];
          default: ;
        endcase
      end
      // Registered valid adds the second cycle of latency and drops after the handshake.
      req_valid_q <= (state == ISSUE) && !(req_valid_q && req_ready);
      if (state == WAIT_RESP && resp_valid) resp_q <= resp_payload;
      if (rx_byte_evt || !collecting) to_cnt <= '0;
      else if (to_cnt != '1)          to_cnt <= to_cnt + 1'b1;
      if (frame_err_inc && frame_err_count != '1) frame_err_count <= frame_err_count + 1'b1;
      if (overrun_inc && overrun_count != '1)     overrun_count   <= overrun_count + 1'b1;
    end
  end

endmodule
